ap_ddr_burst_server: RTL and testbench

Memory-side responder for the associative processor's cache clients. It accepts burst read requests from the instruction and data caches and burst store requests from the data cache, and arbitrates them onto the single native burst port of the DDR controller. It returns the beat-indexed handshakes (`rd_cnt_*`, `*_valid`, `wr_burst_data_req`, `state_interface_module`) that the caches consume.

---
 rtl/ap_mem_pkg.sv | 34 +++
 rtl/ap_beat_counter.sv | 43 ++++
 rtl/ap_ddr_burst_server.sv | 219 +++++++++++++++++++++
 tb/tb_ap_ddr_burst_server.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ap_mem_pkg.sv
// Shared types for the associative processor memory path: FSM state codes
// (visible to the caches through state_interface_module), client select,
// default burst length and the saturating beat-count helper.
package ap_mem_pkg;

  localparam int unsigned BURST_LEN_DEFAULT = 16;
  localparam int unsigned CNT_W             = 10;

  // Codes are observed by the caches; MEM_WRITE_DATA_STORE must stay 4'd9.
  typedef enum logic [3:0] {
    MEM_IDLE             = 4'd0,
    MEM_READ_INSTR       = 4'd1,
    MEM_READ_DATA        = 4'd8,
    MEM_WRITE_DATA_STORE = 4'd9,
    MEM_RELEASE          = 4'd10
  } mem_state_e;

  typedef enum logic [1:0] {
    CL_NONE    = 2'd0,
    CL_INSTR   = 2'd1,
    CL_DATA_RD = 2'd2,
    CL_DATA_WR = 2'd3
  } client_e;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/ap_beat_counter.sv
// Per-client read beat counter: load to 1 on grant, saturating increment on
// each delivered beat, clear when the client is released. Clear wins over
// load, load wins over increment.
module ap_beat_counter
  import ap_mem_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // Next count selection.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (load_i) begin
      cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (inc_i) begin
      cnt_d = sat_inc(cnt_q);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ap_ddr_burst_server.sv
// Arbitrates instruction-cache reads, data-cache reads and data-cache stores
// onto the single DDR burst port (priority store > data read > instr read).
// Optional watchdog: define AP_DDR_TIMEOUT_EN to add ddr_err and abort
// bursts that never finish within TIMEOUT_CYCLES.
module ap_ddr_burst_server
  import ap_mem_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int DDR_ADDR_WIDTH = 28,
  parameter int BURST_LEN      = BURST_LEN_DEFAULT,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      INSTR_read_req,
  input  logic [DDR_ADDR_WIDTH-1:0] INSTR_read_addr,
  output logic [DATA_WIDTH-1:0]     INSTR_to_cache,
  output logic [9:0]                rd_cnt_instr,
  output logic                      rd_burst_instr_valid,
  input  logic                      DATA_read_req,
  input  logic [DDR_ADDR_WIDTH-1:0] DATA_read_addr,
  input  logic                      DATA_store_req,
  input  logic [DDR_ADDR_WIDTH-1:0] DATA_write_addr,
  input  logic [DATA_WIDTH-1:0]     DATA_to_ddr,
  output logic [DATA_WIDTH-1:0]     DATA_to_cache,
  output logic [9:0]                rd_cnt_data,
  output logic                      rd_burst_data_valid,
  output logic                      wr_burst_data_req,
  output logic [3:0]                state_interface_module,
  output logic                      ddr_rd_req,
  output logic [9:0]                ddr_rd_len,
  output logic [DDR_ADDR_WIDTH-1:0] ddr_rd_addr,
  input  logic                      ddr_rd_valid,
  input  logic [DATA_WIDTH-1:0]     ddr_rd_data,
  input  logic                      ddr_rd_finish,
  output logic                      ddr_wr_req,
  output logic [9:0]                ddr_wr_len,
  output logic [DDR_ADDR_WIDTH-1:0] ddr_wr_addr,
  input  logic                      ddr_wr_data_req,
  output logic [DATA_WIDTH-1:0]     ddr_wr_data,
  input  logic                      ddr_wr_finish
`ifdef AP_DDR_TIMEOUT_EN
  ,
  output logic                      ddr_err
`endif
);

  localparam logic [9:0] LEN = 10'(BURST_LEN);

  mem_state_e st_q, st_d;
  client_e    grant_q, grant_d;
  logic rd_req_q, rd_req_d, wr_req_q, wr_req_d;
  logic [9:0] rd_len_q, rd_len_d, wr_len_q, wr_len_d;
  logic [DDR_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] instr_data_q, instr_data_d, data_data_q, data_data_d;
  logic instr_vld_q, instr_vld_d, data_vld_q, data_vld_d;
  logic instr_load_s, instr_inc_s, instr_clr_s;
  logic data_load_s, data_inc_s, data_clr_s;
  logic granted_req_s;
`ifdef AP_DDR_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic err_q, err_d;
`endif

  // Request line of whichever client currently owns the DDR port.
  always_comb begin
    case (grant_q)
      CL_INSTR:   granted_req_s = INSTR_read_req;
      CL_DATA_RD: granted_req_s = DATA_read_req;
      CL_DATA_WR: granted_req_s = DATA_store_req;
      default:    granted_req_s = 1'b0;
    endcase
  end

  // Arbitration, burst sequencing and next-value computation for all flops.
  always_comb begin
    st_d = st_q;          grant_d = grant_q;
    rd_req_d = rd_req_q;  wr_req_d = wr_req_q;
    rd_len_d = rd_len_q;  wr_len_d = wr_len_q;
    rd_addr_d = rd_addr_q; wr_addr_d = wr_addr_q;
    instr_data_d = instr_data_q; data_data_d = data_data_q;
    instr_vld_d = 1'b0;   data_vld_d = 1'b0;
    instr_load_s = 1'b0;  instr_inc_s = 1'b0; instr_clr_s = 1'b0;
    data_load_s = 1'b0;   data_inc_s = 1'b0;  data_clr_s = 1'b0;
    case (st_q)
      MEM_IDLE: begin
        if (DATA_store_req) begin
          st_d = MEM_WRITE_DATA_STORE; grant_d = CL_DATA_WR;
          wr_addr_d = DATA_write_addr; wr_len_d = LEN; wr_req_d = 1'b1;
        end else if (DATA_read_req) begin
          st_d = MEM_READ_DATA; grant_d = CL_DATA_RD;
          rd_addr_d = DATA_read_addr; rd_len_d = LEN; rd_req_d = 1'b1;
          data_load_s = 1'b1;
        end else if (INSTR_read_req) begin
          st_d = MEM_READ_INSTR; grant_d = CL_INSTR;
          rd_addr_d = INSTR_read_addr; rd_len_d = LEN; rd_req_d = 1'b1;
          instr_load_s = 1'b1;
        end else begin
          st_d = MEM_IDLE;
        end
      end
      MEM_READ_INSTR, MEM_READ_DATA: begin
        // A client that dropped its request still lets the burst drain,
        // but its beats are discarded.
        if (ddr_rd_valid) begin
          rd_req_d = 1'b0;
          if (granted_req_s && st_q == MEM_READ_INSTR) begin
            instr_data_d = ddr_rd_data; instr_vld_d = 1'b1; instr_inc_s = 1'b1;
          end else if (granted_req_s) begin
            data_data_d = ddr_rd_data; data_vld_d = 1'b1; data_inc_s = 1'b1;
          end else begin
            instr_vld_d = 1'b0;
          end
        end else begin
          rd_req_d = rd_req_q;
        end
        if (ddr_rd_finish) begin
          st_d = MEM_RELEASE; rd_req_d = 1'b0;
        end else begin
          st_d = st_q;
        end
      end
      MEM_WRITE_DATA_STORE: begin
        if (ddr_wr_data_req) begin
          wr_req_d = 1'b0;
        end else begin
          wr_req_d = wr_req_q;
        end
        if (ddr_wr_finish) begin
          st_d = MEM_RELEASE; wr_req_d = 1'b0;
        end else begin
          st_d = st_q;
        end
      end
      MEM_RELEASE: begin
        // Hold here until the served client lets go, so a held request is
        // not mistaken for a fresh one.
        if (!granted_req_s) begin
          st_d = MEM_IDLE; grant_d = CL_NONE;
          instr_clr_s = (grant_q == CL_INSTR);
          data_clr_s  = (grant_q == CL_DATA_RD);
        end else begin
          st_d = MEM_RELEASE;
        end
      end
      default: begin
        st_d = MEM_IDLE; grant_d = CL_NONE;
        rd_req_d = 1'b0; wr_req_d = 1'b0;
      end
    endcase
`ifdef AP_DDR_TIMEOUT_EN
    err_d = 1'b0;
    if (st_q == MEM_READ_INSTR || st_q == MEM_READ_DATA ||
        st_q == MEM_WRITE_DATA_STORE) begin
      wd_d = wd_q + {{(WD_W-1){1'b0}}, 1'b1};
      if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
        st_d = MEM_RELEASE; rd_req_d = 1'b0; wr_req_d = 1'b0;
        err_d = 1'b1; wd_d = {WD_W{1'b0}};
      end else begin
        err_d = 1'b0;
      end
    end else begin
      wd_d = {WD_W{1'b0}};
    end
`endif
  end

  // State and registered outputs; reset abandons any burst in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q <= MEM_IDLE;      grant_q <= CL_NONE;
      rd_req_q <= 1'b0;      wr_req_q <= 1'b0;
      rd_len_q <= 10'd0;     wr_len_q <= 10'd0;
      rd_addr_q <= '0;       wr_addr_q <= '0;
      instr_data_q <= '0;    data_data_q <= '0;
      instr_vld_q <= 1'b0;   data_vld_q <= 1'b0;
`ifdef AP_DDR_TIMEOUT_EN
      wd_q <= '0;            err_q <= 1'b0;
`endif
    end else begin
      st_q <= st_d;          grant_q <= grant_d;
      rd_req_q <= rd_req_d;  wr_req_q <= wr_req_d;
      rd_len_q <= rd_len_d;  wr_len_q <= wr_len_d;
      rd_addr_q <= rd_addr_d; wr_addr_q <= wr_addr_d;
      instr_data_q <= instr_data_d; data_data_q <= data_data_d;
      instr_vld_q <= instr_vld_d;   data_vld_q <= data_vld_d;
`ifdef AP_DDR_TIMEOUT_EN
      wd_q <= wd_d;          err_q <= err_d;
`endif
    end
  end

  ap_beat_counter u_cnt_instr (
    .clk(clk), .rst(rst), .load_i(instr_load_s), .inc_i(instr_inc_s),
    .clr_i(instr_clr_s), .cnt_o(rd_cnt_instr)
  );

  ap_beat_counter u_cnt_data (
    .clk(clk), .rst(rst), .load_i(data_load_s), .inc_i(data_inc_s),
    .clr_i(data_clr_s), .cnt_o(rd_cnt_data)
  );

  assign state_interface_module = st_q;
  assign ddr_rd_req = rd_req_q;   assign ddr_rd_len = rd_len_q;
  assign ddr_rd_addr = rd_addr_q;
  assign ddr_wr_req = wr_req_q;   assign ddr_wr_len = wr_len_q;
  assign ddr_wr_addr = wr_addr_q;
  assign INSTR_to_cache = instr_data_q; assign rd_burst_instr_valid = instr_vld_q;
  assign DATA_to_cache = data_data_q;   assign rd_burst_data_valid = data_vld_q;
  // The data cache answers a beat request one cycle later; the DDR side
  // samples that cycle, so both paths stay combinational.
  assign wr_burst_data_req = ddr_wr_data_req && (st_q == MEM_WRITE_DATA_STORE);
  assign ddr_wr_data = DATA_to_ddr;
`ifdef AP_DDR_TIMEOUT_EN
  assign ddr_err = err_q;
`endif

endmodule

// File: tb/tb_ap_ddr_burst_server.sv
// Directed bench for ap_ddr_burst_server: data read burst, store burst,
// store-over-instruction priority, held request after finish and
// asynchronous reset in the middle of a read.
module tb_ap_ddr_burst_server;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        INSTR_read_req = 1'b0;
  logic [27:0] INSTR_read_addr = 28'd0;
  logic [15:0] INSTR_to_cache;
  logic [9:0]  rd_cnt_instr;
  logic        rd_burst_instr_valid;
  logic        DATA_read_req = 1'b0;
  logic [27:0] DATA_read_addr = 28'd0;
  logic        DATA_store_req = 1'b0;
  logic [27:0] DATA_write_addr = 28'd0;
  logic [15:0] DATA_to_ddr = 16'd0;
  logic [15:0] DATA_to_cache;
  logic [9:0]  rd_cnt_data;
  logic        rd_burst_data_valid;
  logic        wr_burst_data_req;
  logic [3:0]  state_interface_module;
  logic        ddr_rd_req;
  logic [9:0]  ddr_rd_len;
  logic [27:0] ddr_rd_addr;
  logic        ddr_rd_valid = 1'b0;
  logic [15:0] ddr_rd_data = 16'd0;
  logic        ddr_rd_finish = 1'b0;
  logic        ddr_wr_req;
  logic [9:0]  ddr_wr_len;
  logic [27:0] ddr_wr_addr;
  logic        ddr_wr_data_req = 1'b0;
  logic [15:0] ddr_wr_data;
  logic        ddr_wr_finish = 1'b0;
`ifdef AP_DDR_TIMEOUT_EN
  logic        ddr_err;
`endif

  int total = 0;
  int bad = 0;

  ap_ddr_burst_server dut (
    .clk(clk), .rst(rst),
    .INSTR_read_req(INSTR_read_req), .INSTR_read_addr(INSTR_read_addr),
    .INSTR_to_cache(INSTR_to_cache), .rd_cnt_instr(rd_cnt_instr),
    .rd_burst_instr_valid(rd_burst_instr_valid),
    .DATA_read_req(DATA_read_req), .DATA_read_addr(DATA_read_addr),
    .DATA_store_req(DATA_store_req), .DATA_write_addr(DATA_write_addr),
    .DATA_to_ddr(DATA_to_ddr), .DATA_to_cache(DATA_to_cache),
    .rd_cnt_data(rd_cnt_data), .rd_burst_data_valid(rd_burst_data_valid),
    .wr_burst_data_req(wr_burst_data_req),
    .state_interface_module(state_interface_module),
    .ddr_rd_req(ddr_rd_req), .ddr_rd_len(ddr_rd_len), .ddr_rd_addr(ddr_rd_addr),
    .ddr_rd_valid(ddr_rd_valid), .ddr_rd_data(ddr_rd_data),
    .ddr_rd_finish(ddr_rd_finish),
    .ddr_wr_req(ddr_wr_req), .ddr_wr_len(ddr_wr_len), .ddr_wr_addr(ddr_wr_addr),
    .ddr_wr_data_req(ddr_wr_data_req), .ddr_wr_data(ddr_wr_data),
    .ddr_wr_finish(ddr_wr_finish)
`ifdef AP_DDR_TIMEOUT_EN
    , .ddr_err(ddr_err)
`endif
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; leave the bench 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    // ---------------- reset state
    #3;
    check_val("rst_state", 32'(state_interface_module), 32'd0);
    check_val("rst_rd_req", 32'(ddr_rd_req), 32'd0);
    check_val("rst_wr_req", 32'(ddr_wr_req), 32'd0);
    check_val("rst_cnt_data", 32'(rd_cnt_data), 32'd0);
    check_val("rst_cnt_instr", 32'(rd_cnt_instr), 32'd0);
    check_val("rst_rd_len", 32'(ddr_rd_len), 32'd0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // ---------------- data read at 0x40, request held past finish
    DATA_read_req = 1'b1; DATA_read_addr = 28'h40;
    tick();
    check_val("rd_state", 32'(state_interface_module), 32'd8);
    check_val("rd_req_up", 32'(ddr_rd_req), 32'd1);
    check_val("rd_addr", 32'(ddr_rd_addr), 32'h40);
    check_val("rd_len", 32'(ddr_rd_len), 32'd16);
    check_val("rd_cnt_grant", 32'(rd_cnt_data), 32'd1);
    check_val("rd_cnt_instr_idle", 32'(rd_cnt_instr), 32'd0);
    tick();
    check_val("rd_req_hold", 32'(ddr_rd_req), 32'd1);
    for (int k = 0; k < 16; k++) begin
      ddr_rd_valid = 1'b1; ddr_rd_data = 16'h1000 + 16'(k);
      ddr_rd_finish = (k == 15);
      tick();
      check_val("rd_beat_data", 32'(DATA_to_cache), 32'h1000 + 32'(k));
      check_val("rd_beat_cnt", 32'(rd_cnt_data), 32'(k + 2));
      check_val("rd_beat_vld", 32'(rd_burst_data_valid), 32'd1);
      check_val("rd_req_dropped", 32'(ddr_rd_req), 32'd0);
    end
    ddr_rd_valid = 1'b0; ddr_rd_finish = 1'b0;
    check_val("rd_release", 32'(state_interface_module), 32'd10);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_val("held_state", 32'(state_interface_module), 32'd10);
      check_val("held_no_reissue", 32'(ddr_rd_req), 32'd0);
      check_val("held_cnt", 32'(rd_cnt_data), 32'd17);
      check_val("held_vld", 32'(rd_burst_data_valid), 32'd0);
    end
    DATA_read_req = 1'b0;
    tick();
    check_val("rd_idle", 32'(state_interface_module), 32'd0);
    check_val("rd_cnt_clr", 32'(rd_cnt_data), 32'd0);

    // ---------------- store at 0x80
    DATA_store_req = 1'b1; DATA_write_addr = 28'h80;
    tick();
    check_val("st_state", 32'(state_interface_module), 32'd9);
    check_val("st_wr_req", 32'(ddr_wr_req), 32'd1);
    check_val("st_addr", 32'(ddr_wr_addr), 32'h80);
    check_val("st_len", 32'(ddr_wr_len), 32'd16);
    check_val("st_rd_req", 32'(ddr_rd_req), 32'd0);
    for (int k = 0; k < 16; k++) begin
      ddr_wr_data_req = 1'b1;
      #1;
      check_val("st_beat_req", 32'(wr_burst_data_req), 32'd1);
      tick();
      check_val("st_wr_req_drop", 32'(ddr_wr_req), 32'd0);
      check_val("st_state_beat", 32'(state_interface_module), 32'd9);
      ddr_wr_data_req = 1'b0; DATA_to_ddr = 16'h2000 + 16'(k);
      #1;
      check_val("st_beat_noreq", 32'(wr_burst_data_req), 32'd0);
      check_val("st_wr_data", 32'(ddr_wr_data), 32'h2000 + 32'(k));
      tick();
    end
    ddr_wr_finish = 1'b1;
    tick();
    ddr_wr_finish = 1'b0; DATA_store_req = 1'b0;
    check_val("st_release", 32'(state_interface_module), 32'd10);
    ddr_wr_data_req = 1'b1;
    #1;
    check_val("st_gate_release", 32'(wr_burst_data_req), 32'd0);
    ddr_wr_data_req = 1'b0;
    tick();
    check_val("st_idle", 32'(state_interface_module), 32'd0);

    // ---------------- store beats instruction read when both rise together
    INSTR_read_req = 1'b1; INSTR_read_addr = 28'h100;
    DATA_store_req = 1'b1; DATA_write_addr = 28'hC0;
    tick();
    check_val("pri_state", 32'(state_interface_module), 32'd9);
    check_val("pri_wr_req", 32'(ddr_wr_req), 32'd1);
    check_val("pri_wr_addr", 32'(ddr_wr_addr), 32'hC0);
    check_val("pri_rd_req", 32'(ddr_rd_req), 32'd0);
    check_val("pri_cnt_instr", 32'(rd_cnt_instr), 32'd0);
    ddr_wr_finish = 1'b1;
    tick();
    ddr_wr_finish = 1'b0; DATA_store_req = 1'b0;
    check_val("pri_release", 32'(state_interface_module), 32'd10);
    tick();
    check_val("pri_turn_idle", 32'(state_interface_module), 32'd0);
    check_val("pri_turn_rdreq", 32'(ddr_rd_req), 32'd0);
    tick();
    check_val("pri_instr_state", 32'(state_interface_module), 32'd1);
    check_val("pri_instr_req", 32'(ddr_rd_req), 32'd1);
    check_val("pri_instr_addr", 32'(ddr_rd_addr), 32'h100);
    check_val("pri_instr_cnt", 32'(rd_cnt_instr), 32'd1);
    for (int k = 0; k < 16; k++) begin
      ddr_rd_valid = 1'b1; ddr_rd_data = 16'h3000 + 16'(k);
      ddr_rd_finish = (k == 15);
      tick();
      check_val("in_data", 32'(INSTR_to_cache), 32'h3000 + 32'(k));
      check_val("in_cnt", 32'(rd_cnt_instr), 32'(k + 2));
      check_val("in_vld", 32'(rd_burst_instr_valid), 32'd1);
      check_val("in_other_vld", 32'(rd_burst_data_valid), 32'd0);
      check_val("in_other_cnt", 32'(rd_cnt_data), 32'd0);
    end
    ddr_rd_valid = 1'b0; ddr_rd_finish = 1'b0; INSTR_read_req = 1'b0;
    tick();
    check_val("in_idle", 32'(state_interface_module), 32'd0);
    check_val("in_cnt_clr", 32'(rd_cnt_instr), 32'd0);

    // ---------------- asynchronous reset at beat 5 of a data read
    DATA_read_req = 1'b1; DATA_read_addr = 28'h200;
    tick();
    check_val("rr_req", 32'(ddr_rd_req), 32'd1);
    for (int k = 0; k < 5; k++) begin
      ddr_rd_valid = 1'b1; ddr_rd_data = 16'h4000 + 16'(k);
      tick();
    end
    ddr_rd_valid = 1'b0;
    check_val("rr_pre_cnt", 32'(rd_cnt_data), 32'd6);
    rst = 1'b0;
    #1;
    check_val("rr_state", 32'(state_interface_module), 32'd0);
    check_val("rr_cnt", 32'(rd_cnt_data), 32'd0);
    check_val("rr_data", 32'(DATA_to_cache), 32'd0);
    check_val("rr_vld", 32'(rd_burst_data_valid), 32'd0);
    check_val("rr_addr", 32'(ddr_rd_addr), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    check_val("rr_restart_state", 32'(state_interface_module), 32'd8);
    check_val("rr_restart_cnt", 32'(rd_cnt_data), 32'd1);
    check_val("rr_restart_req", 32'(ddr_rd_req), 32'd1);
    ddr_rd_finish = 1'b1;
    tick();
    ddr_rd_finish = 1'b0; DATA_read_req = 1'b0;
    check_val("rr_release", 32'(state_interface_module), 32'd10);
    check_val("rr_req_off", 32'(ddr_rd_req), 32'd0);
    tick();
    check_val("rr_idle", 32'(state_interface_module), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
